soc_system_status_pio_in: RTL and testbench

//  Avalon-MM slave input port: samples an external WIDTH-bit bus into the HPS

---
 rtl/soc_system_status_pio_in.sv | 124 ++++++++++++
 tb/tb_soc_system_status_pio_in.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/soc_system_status_pio_in.sv
// rtl/soc_system_status_pio_in.sv - Avalon-MM input PIO with edge capture and maskable irq
// Optional mask/irq support: define STATUS_PIO_IRQ_EN.
module soc_system_status_pio_in #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] mask_val;
  logic [2:0]       prime_cnt;
  logic             primed;
  logic             wr_en;
  logic [31:0]      rd_mux;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign data_reg = sync_q[SYNC_STAGES-1];

  // Startup inputs still propagating through the synchronizer must not look like edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '0;
      prime_cnt <= 3'd0;
    end else begin
      prev <= data_reg;
      if (prime_cnt != PRIME_LAST) begin
        prime_cnt <= prime_cnt + 3'd1;
      end
    end
  end

  assign primed = (prime_cnt == PRIME_LAST);
  assign rise   = data_reg & ~prev;
  assign fall   = ~data_reg & prev;

  always_comb begin
    evt = '0;
    if (primed) begin
      case (EDGE_TYPE)
        0:       evt = rise;
        1:       evt = fall;
        default: evt = rise | fall;
      endcase
    end
  end

  assign wr_en = chipselect & ~write_n;

  // A new event on a bit wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture <= '0;
    end else if (wr_en && address == 2'd3) begin
      capture <= (capture & ~writedata[WIDTH-1:0]) | evt;
    end else begin
      capture <= capture | evt;
    end
  end

`ifdef STATUS_PIO_IRQ_EN
  logic [WIDTH-1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
    end else if (wr_en && address == 2'd2) begin
      mask <= writedata[WIDTH-1:0];
    end
  end

  assign mask_val = mask;
  assign irq      = |(capture & mask);
`else
  assign mask_val = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = data_reg;
      2'd2:    rd_mux[WIDTH-1:0] = mask_val;
      2'd3:    rd_mux[WIDTH-1:0] = capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= chipselect ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_soc_system_status_pio_in.sv
// tb/tb_soc_system_status_pio_in.sv - directed bench over rising, falling (8-bit) and any-edge instances
module tb_soc_system_status_pio_in;

`ifdef STATUS_PIO_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write_n;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  soc_system_status_pio_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .in_port(in_port), .irq(irq0));

  soc_system_status_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1),
    .in_port(in_port[7:0]), .irq(irq1));

  soc_system_status_pio_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .in_port(in_port), .irq(irq2));

  function automatic logic [31:0] m(input logic [31:0] v);
    return IRQ_EN ? v : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    chipselect = 1'b1; address = a;
    cyc(1);
    check({tag, "_rise"}, rd0, e0);
    check({tag, "_fall"}, rd1, e1);
    check({tag, "_any"},  rd2, e2);
    chipselect = 1'b0;
  endtask

  task automatic irqchk(input string tag, input logic e0, input logic e1, input logic e2);
    check({tag, "_irq_rise"}, {31'd0, irq0}, {31'd0, e0});
    check({tag, "_irq_fall"}, {31'd0, irq1}, {31'd0, e1});
    check({tag, "_irq_any"},  {31'd0, irq2}, {31'd0, e2});
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = 32'd0; in_port = 32'hFFFF_FFFF;
    cyc(2);
    check("reset_rd_rise", rd0, 32'd0);
    check("reset_rd_any", rd2, 32'd0);
    irqchk("reset", 1'b0, 1'b0, 1'b0);

    // inputs already high when reset releases: no capture
    reset = 1'b0;
    cyc(10);
    rdchk("startup_cap", 2'd3, 32'd0, 32'd0, 32'd0);
    rdchk("startup_data", 2'd0, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF);
    rdchk("addr1", 2'd1, 32'd0, 32'd0, 32'd0);
    irqchk("startup", 1'b0, 1'b0, 1'b0);

    in_port = 32'd0; reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(6);
    rdchk("clean_cap", 2'd3, 32'd0, 32'd0, 32'd0);

    // rising edge on bit 0 with mask 0x1
    wr(2'd2, 32'h1);
    rdchk("mask1", 2'd2, m(32'h1), m(32'h1), m(32'h1));
    in_port = 32'h1;
    cyc(2);
    irqchk("pre_edge", 1'b0, 1'b0, 1'b0);
    cyc(1);
    irqchk("rise0", IRQ_EN, 1'b0, IRQ_EN);
    rdchk("rise0_cap", 2'd3, 32'h1, 32'h0, 32'h1);
    rdchk("rise0_data", 2'd0, 32'h1, 32'h1, 32'h1);

    // partial write-1-to-clear
    in_port = 32'h5;
    cyc(4);
    rdchk("cap5", 2'd3, 32'h5, 32'h0, 32'h5);
    wr(2'd3, 32'h4);
    rdchk("w1c4", 2'd3, 32'h1, 32'h0, 32'h1);
    irqchk("w1c4", IRQ_EN, 1'b0, IRQ_EN);

    // clear of bit 0 lands on the same edge as a new rising event
    in_port = 32'h4;
    cyc(4);
    rdchk("fall0", 2'd3, 32'h1, 32'h1, 32'h1);
    irqchk("fall0", IRQ_EN, IRQ_EN, IRQ_EN);
    in_port = 32'h5;
    cyc(2);
    wr(2'd3, 32'h1);
    rdchk("set_wins", 2'd3, 32'h1, 32'h0, 32'h1);
    wr(2'd3, 32'hFFFF_FFFF);
    rdchk("clear_all", 2'd3, 32'd0, 32'd0, 32'd0);
    irqchk("clear_all", 1'b0, 1'b0, 1'b0);

    // falling edge on bit 3 with mask 0, then unmask
    wr(2'd2, 32'h0);
    in_port = 32'hD;
    cyc(4);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h5;
    cyc(4);
    rdchk("fall3", 2'd3, 32'h0, 32'h8, 32'h8);
    irqchk("fall3_masked", 1'b0, 1'b0, 1'b0);
    wr(2'd2, 32'h108);
    irqchk("fall3_unmask", 1'b0, IRQ_EN, IRQ_EN);
    rdchk("mask108", 2'd2, m(32'h108), m(32'h08), m(32'h108));
    cyc(1);
    check("cs_low_rd", rd0, 32'd0);

    // reset with populated capture/mask and a competing write
    in_port = 32'hFA;
    wr(2'd2, 32'hFF);
    cyc(4);
    irqchk("pre_reset", IRQ_EN, IRQ_EN, IRQ_EN);
    reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'hFF;
    cyc(1);
    irqchk("in_reset", 1'b0, 1'b0, 1'b0);
    check("in_reset_rd", rd0, 32'd0);
    write_n = 1'b1; address = 2'd3;
    cyc(1);
    check("in_reset_rd3", rd2, 32'd0);
    reset = 1'b0; chipselect = 1'b0;
    cyc(8);
    rdchk("post_reset_cap", 2'd3, 32'd0, 32'd0, 32'd0);
    rdchk("post_reset_mask", 2'd2, 32'd0, 32'd0, 32'd0);
    irqchk("post_reset", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
